// File: rtl/recomp_mr_pipe_prog.sv
// Mixed-radix to normalized-digit recomposition pipeline with two modular channels.
// Each stage adds one weighted digit to the residue; the weights are written at run time.
module recomp_mr_pipe_prog #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned MOD0       = 65536,
  parameter int unsigned MOD1       = 78125
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             cin,
  input  logic [NUM_DIGITS*DATA_WIDTH-1:0] mr_dig,
  input  logic                             coef_wr,
  input  logic                             coef_ch,
  input  logic [$clog2(NUM_DIGITS)-1:0]    coef_idx,
  input  logic [DATA_WIDTH-1:0]            coef_data,
  output logic                             coef_err,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            norm_dig_0,
  output logic [DATA_WIDTH-1:0]            norm_dig_1
);

  localparam int unsigned N   = NUM_DIGITS;
  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned PW  = 2 * DW + 1;
  localparam logic [DW-1:0] M0  = DW'(MOD0);
  localparam logic [DW-1:0] M1  = DW'(MOD1);
  localparam logic [PW-1:0] M0W = PW'(MOD0);
  localparam logic [PW-1:0] M1W = PW'(MOD1);

  // Exact residue of acc + dig*w; acc < m, so the sum fits in PW bits.
  function automatic logic [DW-1:0] mac(input logic [DW-1:0] acc, input logic [DW-1:0] dig,
                                        input logic [DW-1:0] w, input logic [PW-1:0] m);
    logic [PW-1:0] s;
    s = PW'(acc) + PW'(dig) * PW'(w);
    return DW'(s % m);
  endfunction

  logic          en;
  logic [N-1:0]  v_q, v_d;
  logic [DW-1:0] acc0_q [N];
  logic [DW-1:0] acc1_q [N];
  logic [DW-1:0] acc0_d [N];
  logic [DW-1:0] acc1_d [N];
  logic [DW-1:0] w0_q   [N];
  logic [DW-1:0] w1_q   [N];
  logic [DW-1:0] dig    [N];
  logic          busy_q, coef_err_q, coef_ok;

  assign en         = !v_q[N-1] || out_ready;
  assign in_ready   = en;
  assign out_valid  = v_q[N-1];
  assign norm_dig_0 = acc0_q[N-1];
  assign norm_dig_1 = acc1_q[N-1];
  assign busy       = busy_q;
  assign coef_err   = coef_err_q;

  assign dig[0] = mr_dig[0 +: DW];

  // Digit k is delayed k enabled cycles so it meets its token at stage k.
  for (genvar k = 1; k < N; k++) begin : g_skew
    logic [DW-1:0] sr [k];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j < k; j++) sr[j] <= '0;
      end else if (en) begin
        sr[0] <= mr_dig[k*DW +: DW];
        for (int j = 1; j < k; j++) sr[j] <= sr[j-1];
      end
    end
    assign dig[k] = sr[k-1];
  end

  // Next pipeline state; everything holds while the output is stalled.
  always_comb begin
    v_d    = v_q;
    acc0_d = acc0_q;
    acc1_d = acc1_q;
    if (en) begin
      v_d[0]    = in_valid;
      acc0_d[0] = mac(DW'(cin), dig[0], w0_q[0], M0W);
      acc1_d[0] = mac(DW'(cin), dig[0], w1_q[0], M1W);
      for (int k = 1; k < N; k++) begin
        v_d[k]    = v_q[k-1];
        acc0_d[k] = mac(acc0_q[k-1], dig[k], w0_q[k], M0W);
        acc1_d[k] = mac(acc1_q[k-1], dig[k], w1_q[k], M1W);
      end
    end
  end

  // Weights may only change while nothing is in flight or arriving.
  assign coef_ok = coef_wr && !busy_q && !in_valid && (32'(coef_idx) < N) &&
                   (coef_ch ? (coef_data < M1) : (coef_data < M0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q        <= '0;
      busy_q     <= 1'b0;
      coef_err_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        acc0_q[k] <= '0;
        acc1_q[k] <= '0;
        w0_q[k]   <= '0;
        w1_q[k]   <= '0;
      end
    end else begin
      v_q        <= v_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      busy_q     <= |v_d;
      coef_err_q <= coef_wr && !coef_ok;
      if (coef_ok) begin
        if (coef_ch) w1_q[coef_idx] <= coef_data;
        else         w0_q[coef_idx] <= coef_data;
      end
    end
  end

endmodule

// File: tb/tb_recomp_mr_pipe_prog.sv
// Directed and randomized bench for recomp_mr_pipe_prog with a residue reference model.
module tb_recomp_mr_pipe_prog;

  localparam int unsigned N    = 6;
  localparam int unsigned DW   = 18;
  localparam int unsigned IW   = 3;
  localparam int unsigned NDW  = N * DW;
  localparam int unsigned MOD0 = 65536;
  localparam int unsigned MOD1 = 78125;

  logic           clk = 1'b0;
  logic           rst_n, in_valid, in_ready, cin;
  logic [NDW-1:0] mr_dig;
  logic           coef_wr, coef_ch, coef_err, busy, out_valid, out_ready;
  logic [IW-1:0]  coef_idx;
  logic [DW-1:0]  coef_data, norm_dig_0, norm_dig_1;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] wm0 [N];
  logic [DW-1:0] wm1 [N];

  recomp_mr_pipe_prog #(.NUM_DIGITS(N), .DATA_WIDTH(DW), .MOD0(MOD0), .MOD1(MOD1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cin(cin),
    .mr_dig(mr_dig), .coef_wr(coef_wr), .coef_ch(coef_ch), .coef_idx(coef_idx),
    .coef_data(coef_data), .coef_err(coef_err), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .norm_dig_0(norm_dig_0), .norm_dig_1(norm_dig_1)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NDW-1:0] mk(input int d5, input int d4, input int d3,
                                        input int d2, input int d1, input int d0);
    return {DW'(d5), DW'(d4), DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  function automatic logic [DW-1:0] model(input logic [NDW-1:0] d, input logic c, input bit ch);
    longint unsigned r, m;
    r = longint'(c);
    m = ch ? longint'(MOD1) : longint'(MOD0);
    for (int k = 0; k < N; k++)
      r = (r + longint'(d[k*DW +: DW]) * longint'(ch ? wm1[k] : wm0[k])) % m;
    return DW'(r);
  endfunction

  task automatic wr(input bit ch, input int idx, input int data, input bit exp_err, input string tag);
    coef_wr = 1'b1; coef_ch = ch; coef_idx = IW'(idx); coef_data = DW'(data);
    tick();
    coef_wr = 1'b0;
    chk(tag, coef_err, exp_err);
    if (!exp_err) begin
      if (ch) wm1[idx] = DW'(data);
      else    wm0[idx] = DW'(data);
    end
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, out_valid, 1);
  endtask

  task automatic send1(input logic [NDW-1:0] d, input logic c, input int e0, input int e1,
                       input string tag);
    in_valid = 1'b1; mr_dig = d; cin = c;
    tick();
    in_valid = 1'b0;
    wait_out(tag);
    chk({tag, "_ch0"}, norm_dig_0, e0);
    chk({tag, "_ch1"}, norm_dig_1, e1);
    tick();
  endtask

  // Producer/consumer loop; stall mode drops out_ready for 3 cycles after 3 results.
  task automatic stream(input int ntok, input bit rnd, input string tag);
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [NDW-1:0] d;
    logic c;
    int sent = 0, recv = 0, cyc = 0, stall_left = 3;
    for (int k = 0; k < N; k++) d[k*DW +: DW] = rnd ? DW'($urandom) : DW'(k + 1);
    c = rnd ? 1'($urandom) : 1'b0;
    while (recv < ntok && cyc < 20000) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(recv == 3 && stall_left > 0);
      in_valid  = (sent < ntok) && (!rnd || ($urandom_range(0, 1) == 1));
      mr_dig = d; cin = c;
      #1;
      if (!out_ready && stall_left > 0 && !rnd) stall_left--;
      if (out_valid && !out_ready) chk({tag, "_in_ready_stall"}, in_ready, 0);
      if (in_valid && in_ready) begin
        q0.push_back(model(d, c, 1'b0));
        q1.push_back(model(d, c, 1'b1));
        sent++;
        for (int k = 0; k < N; k++)
          d[k*DW +: DW] = rnd ? DW'($urandom) : DW'(10 * sent + k + 1);
        c = rnd ? 1'($urandom) : 1'(sent % 2);
      end
      if (out_valid && out_ready) begin
        if (q0.size() == 0) chk({tag, "_spurious"}, out_valid, 0);
        else begin
          chk({tag, "_ch0"}, norm_dig_0, q0.pop_front());
          chk({tag, "_ch1"}, norm_dig_1, q1.pop_front());
        end
        recv++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_count"}, recv, ntok);
  endtask

  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; mr_dig = '0; out_ready = 1'b1;
    coef_wr = 1'b0; coef_ch = 1'b0; coef_idx = '0; coef_data = '0;
    for (int k = 0; k < N; k++) begin wm0[k] = '0; wm1[k] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coef_err", coef_err, 0);
    chk("rst_norm0", norm_dig_0, 0);
    chk("rst_norm1", norm_dig_1, 0);
    chk("rst_in_ready", in_ready, 1);

    // All weights 1; single token with exact latency
    for (int k = 0; k < N; k++) begin
      wr(1'b0, k, 1, 1'b0, "wr_ones0");
      wr(1'b1, k, 1, 1'b0, "wr_ones1");
    end
    in_valid = 1'b1; mr_dig = mk(6, 5, 4, 3, 2, 1); cin = 1'b1;
    for (int i = 1; i <= N; i++) begin
      tick();
      in_valid = 1'b0;
      chk("lat_out_valid", out_valid, (i == N) ? 1 : 0);
    end
    chk("sum_ch0", norm_dig_0, 22);
    chk("sum_ch1", norm_dig_1, 22);
    tick();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_busy", busy, 0);

    // Ten back-to-back tokens with a mid-stream stall
    stream(10, 1'b0, "stream");
    tick();

    // Rejected writes: concurrent with input, while busy, out of range
    in_valid = 1'b1; mr_dig = mk(6, 5, 4, 3, 2, 1); cin = 1'b0;
    coef_wr = 1'b1; coef_ch = 1'b0; coef_idx = IW'(5); coef_data = DW'(9);
    tick();
    in_valid = 1'b0; coef_wr = 1'b0;
    chk("wr_with_input_err", coef_err, 1);
    chk("busy_in_flight", busy, 1);
    wr(1'b0, 0, 5, 1'b1, "wr_busy_err");
    tick();
    chk("err_pulse_end", coef_err, 0);
    wait_out("old_w");
    chk("old_w_ch0", norm_dig_0, 21);
    chk("old_w_ch1", norm_dig_1, 21);
    tick();
    wr(1'b0, 0, 65536, 1'b1, "data_hi0_err");
    wr(1'b1, 0, 78125, 1'b1, "data_hi1_err");
    wr(1'b0, 6, 1, 1'b1, "idx_hi_err");
    tick();
    chk("err_clear", coef_err, 0);
    send1(mk(6, 5, 4, 3, 2, 1), 1'b1, 22, 22, "unchanged_w");

    // Boundary weights on digit 0 only
    wr(1'b0, 0, 65535, 1'b0, "wr_max0");
    wr(1'b1, 0, 78124, 1'b0, "wr_max1");
    for (int k = 1; k < N; k++) begin
      wr(1'b0, k, 0, 1'b0, "wr_zero0");
      wr(1'b1, k, 0, 1'b0, "wr_zero1");
    end
    send1(mk(0, 0, 0, 0, 0, 2), 1'b0, 65534, 78123, "max_w_d2");
    send1(mk(7, 7, 7, 7, 7, 262143), 1'b0, 1, 50357, "max_w_dmax");

    // Reset with three tokens in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mr_dig = mk(1, 2, 3, 4, 5, 100 + i); cin = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin wm0[k] = '0; wm1[k] = '0; end
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) stale++;
      tick();
    end
    chk("no_stale_outputs", stale, 0);
    send1(mk(6, 5, 4, 3, 2, 1), 1'b1, 1, 1, "post_rst");

    // Random weights, random traffic
    for (int k = 0; k < N; k++) begin
      wr(1'b0, k, int'($urandom_range(0, MOD0 - 1)), 1'b0, "wr_rnd0");
      wr(1'b1, k, int'($urandom_range(0, MOD1 - 1)), 1'b0, "wr_rnd1");
    end
    stream(2000, 1'b1, "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
